// File: rtl/gpio_apb_initiator.sv
// gpio_apb_initiator: APB4 initiator driving the nine GPIO registers from a cmd/rsp handshake.
// Ports:
//   pclk, presetn                        clock, async active-low reset
//   cmd_valid_i/cmd_ready_o              command handshake (write, 4-bit index, 32-bit data)
//   rsp_valid_o/rsp_ready_i              response handshake (rdata, err: 00 OK 01 SLVERR 10 TIMEOUT 11 DECERR)
//   paddr_o..pstrb_o, prdata_i..pslverr_i APB4 initiator port
module gpio_apb_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        pclk,
    input  logic        presetn,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_write_i,
    input  logic [3:0]  cmd_idx_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic [1:0]  rsp_err_o,
    output logic [31:0] paddr_o,
    output logic [2:0]  pprot_o,
    output logic        psel_o,
    output logic        penable_o,
    output logic        pwrite_o,
    output logic [31:0] pwdata_o,
    output logic [3:0]  pstrb_o,
    input  logic [31:0] prdata_i,
    input  logic        pready_i,
    input  logic        pslverr_i
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    localparam logic [1:0] ERR_OK = 2'b00, ERR_SLV = 2'b01, ERR_TO = 2'b10, ERR_DEC = 2'b11;
    localparam logic [16:0] TO_LIM = 17'(TIMEOUT_CYCLES);

    state_t      state, state_d;
    logic [15:0] wait_cnt, wait_d;
    logic        cmd_ready_d, rsp_valid_d, psel_d, penable_d, pwrite_d;
    logic [31:0] rsp_rdata_d, paddr_d, pwdata_d;
    logic [1:0]  rsp_err_d;
    logic [3:0]  pstrb_d;
    logic        timed_out;

    assign pprot_o = 3'b000;
    // This ACCESS cycle is the Nth without pready; a completion sampled now still wins.
    assign timed_out = (TO_LIM != 17'd0) && ({1'b0, wait_cnt} + 17'd1 == TO_LIM);

    always_comb begin
        state_d     = state;
        wait_d      = wait_cnt;
        cmd_ready_d = cmd_ready_o;
        rsp_valid_d = rsp_valid_o;
        rsp_rdata_d = rsp_rdata_o;
        rsp_err_d   = rsp_err_o;
        paddr_d     = paddr_o;
        psel_d      = psel_o;
        penable_d   = penable_o;
        pwrite_d    = pwrite_o;
        pwdata_d    = pwdata_o;
        pstrb_d     = pstrb_o;
        case (state)
            IDLE: if (cmd_valid_i) begin
                cmd_ready_d = 1'b0;
                if (cmd_idx_i > 4'd8) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ERR_DEC;
                    rsp_rdata_d = '0;
                end else begin
                    state_d  = SETUP;
                    wait_d   = '0;
                    psel_d   = 1'b1;
                    paddr_d  = {26'd0, cmd_idx_i, 2'b00};
                    pwrite_d = cmd_write_i;
                    pwdata_d = cmd_write_i ? cmd_wdata_i : '0;
                    pstrb_d  = {4{cmd_write_i}};
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: if (pready_i || timed_out) begin
                state_d     = RESP;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
                rsp_valid_d = 1'b1;
                rsp_err_d   = pready_i ? (pslverr_i ? ERR_SLV : ERR_OK) : ERR_TO;
                rsp_rdata_d = (pready_i && !pslverr_i && !pwrite_o) ? prdata_i : '0;
            end else begin
                wait_d = wait_cnt + 16'(wait_cnt != 16'hFFFF);
            end
            RESP: if (rsp_ready_i) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                cmd_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            cmd_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= ERR_OK;
            paddr_o     <= '0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            pwrite_o    <= 1'b0;
            pwdata_o    <= '0;
            pstrb_o     <= '0;
        end else begin
            state       <= state_d;
            wait_cnt    <= wait_d;
            cmd_ready_o <= cmd_ready_d;
            rsp_valid_o <= rsp_valid_d;
            rsp_rdata_o <= rsp_rdata_d;
            rsp_err_o   <= rsp_err_d;
            paddr_o     <= paddr_d;
            psel_o      <= psel_d;
            penable_o   <= penable_d;
            pwrite_o    <= pwrite_d;
            pwdata_o    <= pwdata_d;
            pstrb_o     <= pstrb_d;
        end
    end
endmodule

// File: tb/tb_gpio_apb_initiator.sv
// tb_gpio_apb_initiator: timeline-model bench for gpio_apb_initiator with a reactive APB slave.
module tb_gpio_apb_initiator;
    localparam int N = 16;

    logic        pclk = 1'b0, presetn = 1'b1;
    logic        cmd_valid_i = 1'b0, cmd_write_i = 1'b0, rsp_ready_i = 1'b0;
    logic [3:0]  cmd_idx_i = '0;
    logic [31:0] cmd_wdata_i = '0, prdata_i = '0;
    logic        pready_i = 1'b0, pslverr_i = 1'b0;
    logic        cmd_ready_o, rsp_valid_o, psel_o, penable_o, pwrite_o;
    logic [31:0] rsp_rdata_o, paddr_o, pwdata_o;
    logic [1:0]  rsp_err_o;
    logic [2:0]  pprot_o;
    logic [3:0]  pstrb_o;

    gpio_apb_initiator #(.TIMEOUT_CYCLES(N)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
        .cmd_idx_i(cmd_idx_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .paddr_o(paddr_o), .pprot_o(pprot_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
        .pwdata_o(pwdata_o), .pstrb_o(pstrb_o), .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
    );

    always #5 pclk = ~pclk;

    int checks = 0, errors = 0, cyc = 0;

    // Model: one outstanding command described by its accept edge, ACCESS length and response edge.
    bit          busy = 1'b0, m_dec, m_write, m_slverr;
    int          t_acc, m_len, m_w, rsp_start;
    logic [3:0]  m_idx;
    logic [31:0] m_wdata, m_prdata, exp_rdata;
    logic [1:0]  exp_err;
    int          p_w = 0, rdy_mode = 1;
    logic [31:0] p_prdata = '0;
    logic        p_slverr = 1'b0;
    logic        exp_psel, exp_pen, exp_rv;

    function automatic bit times_out(int w);
        return N > 0 && w + 1 > N;
    endfunction
    function automatic int acc_len(int w);
        return times_out(w) ? N : w + 1;
    endfunction
    function automatic logic [1:0] err_of(logic [3:0] idx, int w, logic se);
        return idx > 4'd8 ? 2'd3 : times_out(w) ? 2'd2 : se ? 2'd1 : 2'd0;
    endfunction

    always @(posedge pclk) cyc <= cyc + 1;

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) busy <= 1'b0;
        else if (busy) begin
            if (cyc >= rsp_start && rsp_ready_i) busy <= 1'b0;
        end else if (cmd_valid_i) begin
            busy      <= 1'b1;
            t_acc     <= cyc + 1;
            m_dec     <= cmd_idx_i > 4'd8;
            m_write   <= cmd_write_i;
            m_idx     <= cmd_idx_i;
            m_wdata   <= cmd_wdata_i;
            m_w       <= p_w;
            m_prdata  <= p_prdata;
            m_slverr  <= p_slverr;
            m_len     <= acc_len(p_w);
            rsp_start <= cmd_idx_i > 4'd8 ? cyc + 1 : cyc + 2 + acc_len(p_w);
            exp_err   <= err_of(cmd_idx_i, p_w, p_slverr);
            exp_rdata <= (err_of(cmd_idx_i, p_w, p_slverr) == 2'd0 && !cmd_write_i) ? p_prdata : 32'd0;
        end
    end

    assign exp_psel = busy && !m_dec && cyc <= t_acc + m_len;
    assign exp_pen  = exp_psel && cyc > t_acc;
    assign exp_rv   = busy && cyc >= rsp_start;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge pclk) begin
        if (!presetn) begin
            chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
            chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
            chk("rst_psel", 32'(psel_o), 32'd0);
            chk("rst_penable", 32'(penable_o), 32'd0);
            chk("rst_pwrite", 32'(pwrite_o), 32'd0);
            chk("rst_paddr", paddr_o, 32'd0);
            chk("rst_pwdata", pwdata_o, 32'd0);
            chk("rst_pstrb", 32'(pstrb_o), 32'd0);
            chk("rst_rdata", rsp_rdata_o, 32'd0);
            chk("rst_err", 32'(rsp_err_o), 32'd0);
        end else begin
            chk("cmd_ready", 32'(cmd_ready_o), 32'(!busy));
            chk("rsp_valid", 32'(rsp_valid_o), 32'(exp_rv));
            chk("psel", 32'(psel_o), 32'(exp_psel));
            chk("penable", 32'(penable_o), 32'(exp_pen));
            chk("pprot", 32'(pprot_o), 32'd0);
            if (exp_psel) begin
                chk("paddr", paddr_o, {26'd0, m_idx, 2'b00});
                chk("pwrite", 32'(pwrite_o), 32'(m_write));
                chk("pstrb", 32'(pstrb_o), m_write ? 32'hF : 32'h0);
                if (m_write) chk("pwdata", pwdata_o, m_wdata);
            end
            if (exp_rv) begin
                chk("rsp_rdata", rsp_rdata_o, exp_rdata);
                chk("rsp_err", 32'(rsp_err_o), 32'(exp_err));
            end
        end
    end

    task automatic step();
        @(posedge pclk);
        #1;
        if (busy && !m_dec && cyc > t_acc && cyc <= t_acc + m_len) begin
            pready_i  = (cyc == t_acc + 1 + m_w);
            prdata_i  = pready_i ? m_prdata : $urandom;
            pslverr_i = pready_i ? m_slverr : 1'($urandom_range(0, 1));
        end else begin
            pready_i  = 1'($urandom_range(0, 1));
            prdata_i  = $urandom;
            pslverr_i = 1'($urandom_range(0, 1));
        end
        rsp_ready_i = rdy_mode == 2 ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
        if (!cmd_valid_i) begin
            cmd_write_i = 1'($urandom_range(0, 1));
            cmd_idx_i   = 4'($urandom);
            cmd_wdata_i = $urandom;
        end
    endtask

    task automatic present(input logic wr, input logic [3:0] idx, input logic [31:0] wd,
                           input int w, input logic [31:0] prd, input logic se);
        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_idx_i   = idx;
        cmd_wdata_i = wd;
        p_w         = w;
        p_prdata    = prd;
        p_slverr    = se;
    endtask

    task automatic wait_acc();
        int n = 0;
        do begin
            step();
            n++;
        end while (!(busy && t_acc == cyc) && n < 200);
        checks++;
        if (!(busy && t_acc == cyc)) begin
            errors++;
            $display("FAIL accept: command not accepted within %0d cycles", n);
        end
        cmd_valid_i = 1'b0;
    endtask

    task automatic issue(input logic wr, input logic [3:0] idx, input logic [31:0] wd,
                         input int w, input logic [31:0] prd, input logic se);
        present(wr, idx, wd, w, prd, se);
        wait_acc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 presetn = 1'b0;
        #1;
        chk("async_rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("async_rst_psel", 32'(psel_o), 32'd0);
        repeat (3) step();
        presetn = 1'b1;
        rdy_mode = 1;
        step();

        issue(1'b1, 4'd2, 32'h0000_00A5, 0, 32'd0, 1'b0);
        chk("wr_setup_psel", 32'(psel_o), 32'd1);
        chk("wr_setup_penable", 32'(penable_o), 32'd0);
        chk("wr_paddr", paddr_o, 32'h08);
        chk("wr_pstrb", 32'(pstrb_o), 32'hF);
        chk("wr_pwdata", pwdata_o, 32'hA5);
        step();
        chk("wr_access_penable", 32'(penable_o), 32'd1);
        step();
        chk("wr_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("wr_rsp_err", 32'(rsp_err_o), 32'd0);
        chk("wr_penable_off", 32'(penable_o), 32'd0);
        step();
        chk("wr_idle_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("wr_idle_rsp_valid", 32'(rsp_valid_o), 32'd0);

        issue(1'b0, 4'd1, 32'd0, 3, 32'h0000_003C, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rd_wait_penable", 32'(penable_o), 32'd1);
            chk("rd_wait_paddr", paddr_o, 32'h04);
        end
        step();
        chk("rd_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("rd_rdata", rsp_rdata_o, 32'h3C);
        chk("rd_err", 32'(rsp_err_o), 32'd0);

        issue(1'b0, 4'd6, 32'd0, 0, 32'hDEAD_BEEF, 1'b1);
        step();
        step();
        chk("slverr_err", 32'(rsp_err_o), 32'd1);
        chk("slverr_rdata", rsp_rdata_o, 32'd0);

        issue(1'b1, 4'd9, 32'h1234_5678, 0, 32'd0, 1'b0);
        chk("decerr_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("decerr_err", 32'(rsp_err_o), 32'd3);
        chk("decerr_psel", 32'(psel_o), 32'd0);

        issue(1'b0, 4'd0, 32'd0, 100, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < N; i++) begin
            step();
            chk("to_penable", 32'(penable_o), 32'd1);
        end
        step();
        chk("to_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("to_err", 32'(rsp_err_o), 32'd2);
        chk("to_rdata", rsp_rdata_o, 32'd0);
        chk("to_psel", 32'(psel_o), 32'd0);

        issue(1'b0, 4'd0, 32'd0, 0, 32'h0000_0055, 1'b0);
        step();
        step();
        chk("after_to_rdata", rsp_rdata_o, 32'h55);
        chk("after_to_err", 32'(rsp_err_o), 32'd0);

        issue(1'b0, 4'd4, 32'd0, N - 1, 32'h1111_2222, 1'b0);
        repeat (N + 1) step();
        chk("last_cycle_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("last_cycle_err", 32'(rsp_err_o), 32'd0);
        chk("last_cycle_rdata", rsp_rdata_o, 32'h1111_2222);

        rdy_mode = 0;
        issue(1'b0, 4'd3, 32'd0, 1, 32'h0000_1234, 1'b0);
        present(1'b1, 4'd5, 32'h0000_CAFE, 0, 32'd0, 1'b0);
        repeat (3) step();
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp_valid", 32'(rsp_valid_o), 32'd1);
            chk("hold_rdata", rsp_rdata_o, 32'h1234);
            chk("hold_cmd_ready", 32'(cmd_ready_o), 32'd0);
            step();
        end
        rdy_mode = 1;
        wait_acc();
        step();
        step();
        chk("pending_rsp_valid", 32'(rsp_valid_o), 32'd1);
        chk("pending_err", 32'(rsp_err_o), 32'd0);

        issue(1'b1, 4'd2, 32'h0000_0077, 5, 32'd0, 1'b0);
        step();
        step();
        chk("mid_access_penable", 32'(penable_o), 32'd1);
        #2 presetn = 1'b0;
        #1;
        chk("abort_psel", 32'(psel_o), 32'd0);
        chk("abort_penable", 32'(penable_o), 32'd0);
        chk("abort_paddr", paddr_o, 32'd0);
        chk("abort_pwrite", 32'(pwrite_o), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready_o), 32'd1);
        step();
        step();
        presetn = 1'b1;
        step();
        chk("post_abort_cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("post_abort_rsp_valid", 32'(rsp_valid_o), 32'd0);

        rdy_mode = 2;
        repeat (300) begin
            int r, w;
            logic [3:0] idx;
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) step();
            r = $urandom_range(0, 9);
            w = r < 6 ? $urandom_range(0, 3) : r == 6 ? N - 1 : r == 7 ? N : r == 8 ? $urandom_range(N + 1, N + 14) : $urandom_range(4, N - 2);
            idx = $urandom_range(0, 9) == 0 ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            issue(1'($urandom_range(0, 1)), idx, $urandom, w, $urandom, 1'($urandom_range(0, 3) == 0));
        end
        begin
            int n = 0;
            while (busy && n < 100) begin
                step();
                n++;
            end
            checks++;
            if (busy) begin
                errors++;
                $display("FAIL drain: response not consumed within %0d cycles", n);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
